// File: rtl/cpu_bus_seq.sv
// CPU request to multiplexed address/data bus sequencer.
// Optional ready timeout enabled by CPU_BUS_SEQ_TIMEOUT_EN.
module cpu_bus_seq #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TMO_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req,
  input  logic [DW/8-1:0] cpu_write,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_ack_o,
  output logic [DW-1:0]   cpu_rdata_o,
  output logic            cpu_error_o,
  output logic [DW-1:0]   bus_ad_o,
  output logic            bus_ad_oe_o,
  input  logic [DW-1:0]   bus_ad_i,
  output logic            bus_adrcyn_o,
  output logic            bus_tm1n_o,
  output logic            bus_tm0n_o,
  input  logic            bus_rdyn_i
);

  localparam int SW = DW / 8;
  localparam int LB = (DW == 64) ? 3 : 2;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [SW-1:0] strb_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    tm_q;
  logic [LB-1:0] lane_q;
  logic          err_q;

  logic [7:0]    s8;
  logic [4:0]    e;
  logic          enc_ok;
  logic [1:0]    enc_tm;
  logic [LB-1:0] enc_lane;
  logic [DW-1:0] a_word;
  logic          tmo_hit;

  // {legal, tm1n/tm0n, lane code} for one 32-bit half
  function automatic logic [4:0] enc4(input logic [3:0] s);
    case (s)
      4'b0000: enc4 = 5'b1_11_00;
      4'b0001: enc4 = 5'b1_00_00;
      4'b0010: enc4 = 5'b1_00_01;
      4'b0100: enc4 = 5'b1_00_10;
      4'b1000: enc4 = 5'b1_00_11;
      4'b0011: enc4 = 5'b1_01_01;
      4'b1100: enc4 = 5'b1_01_11;
      4'b1111: enc4 = 5'b1_01_00;
      default: enc4 = 5'b0_11_00;
    endcase
  endfunction

  always_comb begin
    s8       = 8'(cpu_write);
    e        = 5'b0_11_00;
    enc_ok   = 1'b0;
    enc_tm   = 2'b11;
    enc_lane = '0;
    if (DW == 64 && s8 == 8'hFF) begin
      enc_ok = 1'b1;
      enc_tm = 2'b10;
    end else if (s8[7:4] == 4'h0) begin
      e        = enc4(s8[3:0]);
      enc_ok   = e[4];
      enc_tm   = e[3:2];
      enc_lane = LB'({1'b0, e[1:0]});
    end else if (DW == 64 && s8[3:0] == 4'h0) begin
      e        = enc4(s8[7:4]);
      enc_ok   = e[4];
      enc_tm   = e[3:2];
      enc_lane = LB'({1'b1, e[1:0]});
    end
  end

`ifdef CPU_BUS_SEQ_TIMEOUT_EN
  logic [7:0] tmo_q;

  assign tmo_hit = bus_rdyn_i && (tmo_q == 8'(TMO_CYC - 1));

  // ADDR always precedes DATA, so clearing there clears on DATA entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == ADDR) begin
      tmo_q <= '0;
    end else if (state_q == DATA && bus_rdyn_i) begin
      tmo_q <= tmo_q + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cpu_req) state_d = enc_ok ? ADDR : DONE;
      ADDR: state_d = DATA;
      DATA: if (!bus_rdyn_i || tmo_hit) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      strb_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tm_q    <= 2'b11;
      lane_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && cpu_req) begin
        strb_q  <= cpu_write;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        tm_q    <= enc_tm;
        lane_q  <= enc_lane;
        err_q   <= !enc_ok;
      end
      if (state_q == DATA && tmo_hit) err_q <= 1'b1;
      if (state_q == DATA && !bus_rdyn_i && strb_q == '0)
        rdata_q <= bus_ad_i;
    end
  end

  always_comb begin
    a_word         = DW'(addr_q);
    a_word[LB-1:0] = lane_q;
  end

  assign cpu_ack_o   = (state_q == DONE);
  assign cpu_error_o = (state_q == DONE) && err_q;
  assign cpu_rdata_o = rdata_q;

  always_comb begin
    bus_ad_o     = '0;
    bus_ad_oe_o  = 1'b0;
    bus_adrcyn_o = 1'b1;
    bus_tm1n_o   = 1'b1;
    bus_tm0n_o   = 1'b1;
    unique case (state_q)
      ADDR: begin
        bus_adrcyn_o = 1'b0;
        bus_ad_oe_o  = 1'b1;
        bus_ad_o     = a_word;
        {bus_tm1n_o, bus_tm0n_o} = tm_q;
      end
      DATA: begin
        {bus_tm1n_o, bus_tm0n_o} = tm_q;
        if (strb_q != '0) begin
          bus_ad_oe_o = 1'b1;
          bus_ad_o    = wdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule
